// File: rtl/request_decoder_pkg.sv
// request_decoder_pkg: shared state encoding, default lengths, counter width and decode table
package request_decoder_pkg;
  localparam int CNT_W = 8;
  localparam int DEF_PULSE_LEN = 4;
  localparam int DEF_GAP_LEN = 1;
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, GAP = 2'd2} state_t;
  function automatic logic [3:0] decode(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction
endpackage

// File: rtl/request_decoder_pulse_timer.sv
// pulse_timer: 8-bit loadable down-counter with zero flag, shared by DRIVE and GAP
//   clk, rst (async high) | i_load, i_value: load length-1 | i_dec: count down | o_zero: count is 0
module pulse_timer
  import request_decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  input  logic             i_dec,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_count;
  assign o_zero = r_count == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_count <= '0;
    else if (i_load) r_count <= i_value;
    else if (i_dec && !o_zero) r_count <= r_count - CNT_W'(1);
endmodule

// File: rtl/request_decoder.sv
// request_decoder: accepts a 2-bit code and holds its one-hot decode for PULSE_LEN cycles, then idles GAP_LEN cycles
//   clk, rst (async high) | code, valid: request in | ready: IDLE | busy: !ready
//   d: registered one-hot | drop: request refused last cycle | accept_cnt: wrapping transfer count
module request_decoder
  import request_decoder_pkg::*;
#(
  parameter int PULSE_LEN = DEF_PULSE_LEN,
  parameter int GAP_LEN   = DEF_GAP_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       code,
  input  logic             valid,
  output logic             ready,
  output logic [3:0]       d,
  output logic             busy,
  output logic             drop,
  output logic [CNT_W-1:0] accept_cnt
);
  state_t           r_state, w_state_n;
  logic [1:0]       r_code, w_code_n;
  logic [3:0]       r_d;
  logic             r_drop;
  logic [CNT_W-1:0] r_cnt, w_load_val;
  logic             w_xfer, w_zero, w_load, w_dec, w_end_drive;
  assign ready      = r_state == IDLE;
  assign busy       = !ready;
  assign d          = r_d;
  assign drop       = r_drop;
  assign accept_cnt = r_cnt;
  assign w_xfer     = valid && ready;
  assign w_code_n   = w_xfer ? code : r_code;
  pulse_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_value (w_load_val),
    .i_dec   (w_dec),
    .o_zero  (w_zero)
  );
  // The timer sits at 0 in IDLE, so DRIVE with GAP_LEN=0 returns straight to IDLE without a reload.
  always_comb begin
    w_state_n   = IDLE;
    w_end_drive = r_state == DRIVE && w_zero;
    w_load      = w_xfer || (w_end_drive && GAP_LEN != 0);
    w_load_val  = w_xfer ? CNT_W'(PULSE_LEN - 1) : CNT_W'(GAP_LEN - 1);
    w_dec       = !w_zero && !ready;
    w_state_n   = w_xfer ? DRIVE :
                  w_end_drive ? (GAP_LEN == 0 ? IDLE : GAP) :
                  (r_state == DRIVE || (r_state == GAP && !w_zero)) ? r_state : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_code  <= '0;
      r_d     <= '0;
      r_drop  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_code  <= w_code_n;
      r_d     <= w_state_n == DRIVE ? decode(w_code_n) : 4'b0000;
      r_drop  <= valid && !ready;
      r_cnt   <= r_cnt + CNT_W'(w_xfer);
    end
endmodule

// File: tb/tb_request_decoder.sv
// tb_request_decoder: scoreboard bench for request_decoder (default lengths) plus a PULSE_LEN=1/GAP_LEN=0 instance
module tb_request_decoder;
  localparam int P = 4;
  localparam int G = 1;
  typedef struct packed {
    logic [3:0] d;
    logic       ready;
    logic       busy;
    logic       drop;
    logic [7:0] cnt;
  } exp_t;
  logic       clk = 1'b0, rst = 1'b1;
  logic [1:0] code = '0, code2 = '0;
  logic       valid = 1'b0, valid2 = 1'b0;
  logic       ready, busy, drop, ready2, busy2, drop2;
  logic [3:0] d, d2;
  logic [7:0] accept_cnt, accept_cnt2;
  int         n_checks = 0, n_fail = 0;
  int         k = 1000;
  logic [1:0] m_code = '0;
  logic [7:0] m_cnt = '0;
  logic       m_drop = 1'b0;
  exp_t       q[$];
  always #5 clk = ~clk;
  request_decoder #(.PULSE_LEN(P), .GAP_LEN(G)) u_dut (
    .clk(clk), .rst(rst), .code(code), .valid(valid), .ready(ready),
    .d(d), .busy(busy), .drop(drop), .accept_cnt(accept_cnt)
  );
  request_decoder #(.PULSE_LEN(1), .GAP_LEN(0)) u_dut2 (
    .clk(clk), .rst(rst), .code(code2), .valid(valid2), .ready(ready2),
    .d(d2), .busy(busy2), .drop(drop2), .accept_cnt(accept_cnt2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    k = 1000;
    m_code = '0;
    m_cnt = '0;
    m_drop = 1'b0;
  endtask
  // k counts cycles since the last accept: DRIVE for k<P, GAP for P<=k<P+G, IDLE after.
  task automatic step(input logic v, input logic [1:0] c);
    exp_t e;
    logic rdy;
    valid = v;
    code = c;
    rdy = k >= P + G;
    if (v && rdy) begin
      k = 0;
      m_code = c;
      m_cnt = m_cnt + 8'd1;
      m_drop = 1'b0;
    end else begin
      m_drop = v;
      if (k < 1000) k++;
    end
    e.d = k < P ? 4'b0001 << m_code : 4'b0000;
    e.ready = k >= P + G;
    e.busy = !e.ready;
    e.drop = m_drop;
    e.cnt = m_cnt;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = q.pop_front();
    check("d", d, e.d);
    check("ready", ready, e.ready);
    check("busy", busy, e.busy);
    check("drop", drop, e.drop);
    check("accept_cnt", accept_cnt, e.cnt);
  endtask
  initial begin
    #1;
    check("rst_d", d, 4'b0000);
    check("rst_ready", ready, 1'b1);
    check("rst_drop", drop, 1'b0);
    check("rst_cnt", accept_cnt, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 2'd2);
    for (int i = 0; i < 6; i++) step(1'b0, 2'd0);
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 6; i++) step(i == 0, 2'(c));
    for (int i = 0; i < 12; i++) step(1'b1, 2'd3);
    for (int i = 0; i < 80; i++) step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));
    for (int i = 0; i < 6; i++) step(1'b0, 2'd0);
    step(1'b1, 2'd1);
    step(1'b0, 2'd1);
    rst = 1'b1;
    #1;
    check("arst_d", d, 4'b0000);
    check("arst_ready", ready, 1'b1);
    check("arst_busy", busy, 1'b0);
    check("arst_cnt", accept_cnt, 8'd0);
    model_reset();
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b0, 2'd1);
    for (int i = 0; i < 256 * (P + G + 1); i++) step(1'b1, 2'(i / (P + G + 1)));
    check("wrap_cnt", accept_cnt, 8'd0);
    for (int i = 0; i < 12; i++) begin
      code2 = 2'(i);
      valid2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("p1_d", d2, i % 2 == 0 ? 4'b0001 << (i % 4) : 4'b0000);
      check("p1_ready", ready2, i % 2 == 1);
      check("p1_drop", drop2, i % 2 == 1);
      check("p1_cnt", accept_cnt2, 8'(i / 2 + 1));
    end
    valid2 = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/request_decoder.md
REQUEST_DECODER -- requirements
Module: request_decoder

Interface
REQ-001 Parameter PULSE_LEN, default 4, number of cycles the one-hot output is held (legal 1..255).
REQ-002 Parameter GAP_LEN, default 1, idle cycles forced after each pulse before re-accept (legal 0..255).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 code  input  2  encoded request index (3 = highest).
REQ-006 valid  input  1  code qualifier; a transfer occurs on a rising edge where valid=1 and ready=1.
REQ-007 ready  output  1  block can accept a code this cycle.
REQ-008 d  output  4  registered one-hot decoded request.
REQ-009 busy  output  1  pulse or gap in progress.
REQ-010 drop  output  1  one-cycle flag: a request was refused.
REQ-011 accept_cnt  output  8  count of accepted transfers.

Function
REQ-012 Decode table SHALL be: code 3 -> d=4'b1000, 2 -> 4'b0100, 1 -> 4'b0010, 0 -> 4'b0001.
REQ-013 FSM states SHALL be IDLE, DRIVE, GAP; d SHALL be 4'b0000 in IDLE and GAP.
REQ-014 ready SHALL equal (state==IDLE); busy SHALL equal not ready.
REQ-015 On a transfer at edge N, code SHALL be latched and state SHALL enter DRIVE, with d one-hot from edge N through edge N+PULSE_LEN (exactly PULSE_LEN cycles).
REQ-016 At the end of DRIVE the state SHALL enter GAP for GAP_LEN cycles, or IDLE directly when GAP_LEN=0.
REQ-017 At the end of GAP the state SHALL enter IDLE; a valid present in that first IDLE cycle SHALL be accepted.
REQ-018 Back-to-back throughput SHALL be one transfer per PULSE_LEN+GAP_LEN+1 cycles with valid held high.
REQ-019 valid=1 while ready=0 SHALL be ignored (no state, d or code change) and SHALL assert drop on the following cycle for one cycle per refused cycle.
REQ-020 code changes during DRIVE SHALL NOT affect d.
REQ-021 accept_cnt SHALL increment by 1 on each transfer edge and wrap 255 -> 0 without a flag.
REQ-022 drop and accept_cnt SHALL be registered outputs; d SHALL be registered.
REQ-023 The internal timer SHALL be 8 bits, loaded with length-1 on state entry and decremented to 0.

Reset
REQ-024 rst=1 SHALL immediately, without a clock edge, force state=IDLE, d=0, drop=0, accept_cnt=0, timer=0, latched code=0.
REQ-025 Reset asserted mid-DRIVE or mid-GAP SHALL abort the operation; no pulse remainder SHALL appear after release.
REQ-026 The first rising edge after rst deasserts SHALL be able to accept a transfer.

Structure
REQ-027 A shared package request_decoder_pkg SHALL hold the state encoding constants (IDLE=2'd0, DRIVE=2'd1, GAP=2'd2), default PULSE_LEN/GAP_LEN and the 8-bit counter width.
REQ-028 The down-counter SHALL be a sub-module pulse_timer (load, value, decrement, zero flag) reused for DRIVE and GAP.
REQ-029 The decode table SHALL be a single combinational function/case feeding the d register; no latches.

Verification
REQ-030 Reset release, valid=1 code=2 at edge 1 -> d=0100 for 4 cycles, then 0000 for 1 cycle, ready=1 again, accept_cnt=1.
REQ-031 All codes 0..3 sequentially -> d=0001,0010,0100,1000 each 4 cycles, accept_cnt=4.
REQ-032 valid held high, code=3, 10 cycles after accept -> drop=1 each refused cycle, d unchanged, second accept exactly 6 cycles after the first.
REQ-033 rst pulsed in 2nd DRIVE cycle -> d=0000 and ready=1 before next edge, accept_cnt=0, no residual pulse.
REQ-034 GAP_LEN=0, PULSE_LEN=1, valid always high -> transfer every 2 cycles, no GAP state visited.
REQ-035 256 transfers -> accept_cnt wraps to 0, no other side effect.
